// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the adding machine's single-port program/data memory between the
// CPU datapath (instruction fetch, AC store) and the host loader port
// (program load, result readback). Every access is serialised through a
// small FSM: IDLE (arbitrate) -> ISSUE (one memory strobe) -> WAIT (read
// latency) -> ACK (one-cycle completion pulse) -> IDLE.
//
// The host wins ties. A burst counter caps how many host grants in a row
// can be made while the CPU is waiting, so the CPU cannot be starved.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-low reset
//   cpu_req/we/addr/wdata  CPU request; fields held stable while req is high
//   cpu_rdata, cpu_ack     CPU read data (held until next CPU read) and ack
//   host_req/we/addr/wdata host request, same handshake as the CPU
//   host_rdata, host_ack   host read data and ack
//   mem_en/we/addr/wdata   memory strobe and fields, non-zero only in ISSUE
//   mem_rdata              memory read data, valid RD_LAT cycles after mem_en
//   busy                   high whenever an access is in flight
//   grant_host             high while the in-flight access belongs to host
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW             = 6,
    parameter int DW             = 8,
    parameter int RD_LAT         = 1,
    parameter int HOST_BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_host
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    localparam int CW = $clog2(RD_LAT + 1);
    localparam int BW = $clog2(HOST_BURST_MAX + 1);
    localparam logic [CW-1:0] LAT_LOAD    = CW'(RD_LAT);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(HOST_BURST_MAX);

    state_t        state_q,     state_d;
    logic          ownerHost_q, ownerHost_d;
    logic          we_q,        we_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [DW-1:0] wdata_q,     wdata_d;
    logic [CW-1:0] waitCnt_q,   waitCnt_d;
    logic [BW-1:0] burstCnt_q,  burstCnt_d;
    logic [DW-1:0] cpuRdata_q,  cpuRdata_d;
    logic [DW-1:0] hostRdata_q, hostRdata_d;
    logic          grantHost;

    // Next-state logic. Arbitration and request capture happen only in IDLE;
    // once captured, the access runs to completion from the internal copies
    // regardless of what the requester does with its inputs.
    always_comb begin
        state_d     = state_q;
        ownerHost_d = ownerHost_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        waitCnt_d   = waitCnt_q;
        burstCnt_d  = burstCnt_q;
        cpuRdata_d  = cpuRdata_q;
        hostRdata_d = hostRdata_q;
        grantHost   = 1'b0;

        case (state_q)
            IDLE: begin
                if (host_req || cpu_req) begin
                    // Host wins a tie unless it has already used up its
                    // allowance of consecutive grants over a waiting CPU.
                    grantHost   = host_req && (!cpu_req || (burstCnt_q != BURST_LIMIT));
                    ownerHost_d = grantHost;
                    state_d     = ISSUE;
                    if (grantHost) begin
                        we_d    = host_we;
                        addr_d  = host_addr;
                        wdata_d = host_wdata;
                        // Only host grants that actually made the CPU wait
                        // count towards the burst limit.
                        if (cpu_req) begin
                            burstCnt_d = (burstCnt_q == BURST_LIMIT) ? burstCnt_q
                                                                     : burstCnt_q + 1'b1;
                        end else begin
                            burstCnt_d = '0;
                        end
                    end else begin
                        we_d       = cpu_we;
                        addr_d     = cpu_addr;
                        wdata_d    = cpu_wdata;
                        burstCnt_d = '0;
                    end
                end
            end

            ISSUE: begin
                if (we_q) begin
                    state_d = ACK;
                end else begin
                    waitCnt_d = LAT_LOAD;
                    state_d   = WAIT;
                end
            end

            // WAIT covers the whole read latency; the last WAIT cycle is the
            // one in which mem_rdata is valid, so it is captured there and the
            // ack in the following cycle already carries the data.
            WAIT: begin
                if (waitCnt_q == CW'(1)) begin
                    if (ownerHost_q) begin
                        hostRdata_d = mem_rdata;
                    end else begin
                        cpuRdata_d = mem_rdata;
                    end
                    state_d = ACK;
                end else begin
                    waitCnt_d = waitCnt_q - 1'b1;
                end
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any in-flight access
    // without acknowledging it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ownerHost_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            waitCnt_q   <= '0;
            burstCnt_q  <= '0;
            cpuRdata_q  <= '0;
            hostRdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ownerHost_q <= ownerHost_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            waitCnt_q   <= waitCnt_d;
            burstCnt_q  <= burstCnt_d;
            cpuRdata_q  <= cpuRdata_d;
            hostRdata_q <= hostRdata_d;
        end
    end

    // The memory bus is forced to zero outside ISSUE so a stray mem_we or
    // address can never be seen by the array between accesses.
    assign mem_en     = (state_q == ISSUE);
    assign mem_we     = mem_en && we_q;
    assign mem_addr   = mem_en ? addr_q  : '0;
    assign mem_wdata  = mem_en ? wdata_q : '0;

    assign busy       = (state_q != IDLE);
    assign grant_host = busy && ownerHost_q;
    assign cpu_ack    = (state_q == ACK) && !ownerHost_q;
    assign host_ack   = (state_q == ACK) &&  ownerHost_q;
    assign cpu_rdata  = cpuRdata_q;
    assign host_rdata = hostRdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. A behavioural memory supplies read data with
// the configured latency. The reference model works at transaction level:
// at each grant it schedules the issue cycle and ack cycle of the access as
// plain cycle numbers, and every cycle the DUT outputs are compared with
// what that schedule implies. Directed sequences cover reset, single reads
// and writes, the host burst limit, reset during a read and a request
// dropped mid-access; a randomized phase then exercises both requesters.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW     = 6;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;
    localparam int HBM    = 4;

    logic          clk;
    logic          reset;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          grant_host;

    mem_port_arbiter #(
        .AW(AW),
        .DW(DW),
        .RD_LAT(RD_LAT),
        .HOST_BURST_MAX(HBM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack),
        .host_req(host_req),
        .host_we(host_we),
        .host_addr(host_addr),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .host_ack(host_ack),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy),
        .grant_host(grant_host)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port memory. The ISSUE cycle is observed on the
    // falling edge; the read value then walks a latency pipe and is placed
    // on mem_rdata just after a rising edge so it is stable for the whole
    // cycle in which it is valid. Outside that cycle the bus carries noise.
    logic [DW-1:0] mem  [64];
    logic [DW-1:0] pipe [RD_LAT];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
        mem[5] = 8'hA7;
        for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = (mem_en && !mem_we) ? mem[mem_addr] : DW'($urandom);
            if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
            @(posedge clk);
            #1 mem_rdata = pipe[RD_LAT-1];
        end
    end

    // Reference model state: one scheduled access at most.
    int            checks;
    int            failures;
    int            cyc;
    bit            accessLive;
    int            issueCyc;
    int            ackCyc;
    bit            ownerHost;
    bit            isWrite;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    logic [DW-1:0] expReadVal;
    logic [DW-1:0] expCpuRdata;
    logic [DW-1:0] expHostRdata;
    int            burst;
    bit            cpuInFlight;
    bit            hostInFlight;
    int            cpuAckAt;
    int            hostAckAt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compares every DUT output with what the scheduled access implies.
    task automatic checkCycle();
        bit issueNow;
        bit busyNow;
        bit ackNow;
        issueNow = accessLive && (cyc == issueCyc);
        busyNow  = accessLive && (cyc >= issueCyc) && (cyc <= ackCyc);
        ackNow   = accessLive && (cyc == ackCyc);
        if (ackNow && !isWrite) begin
            if (ownerHost) expHostRdata = expReadVal;
            else           expCpuRdata  = expReadVal;
        end
        checkOutput("mem_en",     32'(mem_en),     32'(issueNow));
        checkOutput("mem_we",     32'(mem_we),     32'(issueNow && isWrite));
        checkOutput("mem_addr",   32'(mem_addr),   issueNow ? 32'(expAddr)  : 32'd0);
        checkOutput("mem_wdata",  32'(mem_wdata),  issueNow ? 32'(expWdata) : 32'd0);
        checkOutput("busy",       32'(busy),       32'(busyNow));
        checkOutput("grant_host", 32'(grant_host), 32'(busyNow && ownerHost));
        checkOutput("cpu_ack",    32'(cpu_ack),    32'(ackNow && !ownerHost));
        checkOutput("host_ack",   32'(host_ack),   32'(ackNow && ownerHost));
        checkOutput("cpu_rdata",  32'(cpu_rdata),  32'(expCpuRdata));
        checkOutput("host_rdata", 32'(host_rdata), 32'(expHostRdata));
        if (ackNow) begin
            if (ownerHost) begin
                hostAckAt    = cyc;
                hostInFlight = 1'b0;
            end else begin
                cpuAckAt    = cyc;
                cpuInFlight = 0;
            end
            accessLive = 1'b0;
        end
    endtask

    // Applies the arbitration rules to the inputs presented in this cycle.
    task automatic modelStep();
        bit gh;
        if (!reset) begin
            accessLive   = 1'b0;
            ackCyc       = cyc;
            issueCyc     = -100;
            burst        = 0;
            expCpuRdata  = '0;
            expHostRdata = '0;
            cpuInFlight  = 1'b0;
            hostInFlight = 1'b0;
        end else if (!accessLive && (cyc > ackCyc) && (cpu_req || host_req)) begin
            gh = host_req && (!cpu_req || (burst != HBM));
            if (gh) burst = cpu_req ? ((burst < HBM) ? burst + 1 : HBM) : 0;
            else    burst = 0;
            ownerHost  = gh;
            isWrite    = gh ? host_we    : cpu_we;
            expAddr    = gh ? host_addr  : cpu_addr;
            expWdata   = gh ? host_wdata : cpu_wdata;
            expReadVal = mem[expAddr];
            issueCyc   = cyc + 1;
            ackCyc     = isWrite ? cyc + 2 : cyc + RD_LAT + 2;
            accessLive = 1'b1;
            if (gh) hostInFlight = 1'b1;
            else    cpuInFlight  = 1'b1;
        end
    endtask

    task automatic stepCycle();
        modelStep();
        @(negedge clk);
        cyc++;
        checkCycle();
    endtask

    task automatic waitAck(input bit forHost, input string tag);
        int n;
        n = 0;
        while (!(forHost ? host_ack : cpu_ack) && (n < 50)) begin
            stepCycle();
            n++;
        end
        checkOutput(tag, 32'(forHost ? host_ack : cpu_ack), 32'd1);
    endtask

    // Random requester behaviour: raise with random fields, hold until the
    // grant, optionally drop (and scramble fields) once granted, always drop
    // in the cycle after the ack. Occasional one-cycle resets.
    task automatic applyStimulus();
        reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        if (cyc == cpuAckAt + 1) begin
            cpu_req = 1'b0;
        end else if (cpu_req && cpuInFlight && ($urandom_range(0, 3) == 0)) begin
            cpu_req   = 1'b0;
            cpu_we    = 1'($urandom);
            cpu_addr  = AW'($urandom);
            cpu_wdata = DW'($urandom);
        end else if (!cpu_req && !cpuInFlight && (cyc != cpuAckAt) && ($urandom_range(0, 2) == 0)) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'($urandom);
            cpu_addr  = AW'($urandom);
            cpu_wdata = DW'($urandom);
        end
        if (cyc == hostAckAt + 1) begin
            host_req = 1'b0;
        end else if (host_req && hostInFlight && ($urandom_range(0, 3) == 0)) begin
            host_req   = 1'b0;
            host_we    = 1'($urandom);
            host_addr  = AW'($urandom);
            host_wdata = DW'($urandom);
        end else if (!host_req && !hostInFlight && (cyc != hostAckAt) && ($urandom_range(0, 2) == 0)) begin
            host_req   = 1'b1;
            host_we    = 1'($urandom);
            host_addr  = AW'($urandom);
            host_wdata = DW'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int       c1;
        int       acks;
        logic [9:0] order;
        logic [DW-1:0] exp7;

        checks = 0; failures = 0; cyc = 0;
        accessLive = 1'b0; issueCyc = -100; ackCyc = -1;
        ownerHost = 1'b0; isWrite = 1'b0; expAddr = '0; expWdata = '0; expReadVal = '0;
        expCpuRdata = '0; expHostRdata = '0; burst = 0;
        cpuInFlight = 1'b0; hostInFlight = 1'b0; cpuAckAt = -10; hostAckAt = -10;

        // Reset held three cycles with both requesters active.
        reset = 1'b0;
        cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 6'h05;  cpu_wdata = 8'h00;
        host_req = 1'b1; host_we = 1'b1; host_addr = 6'h3F; host_wdata = 8'h55;
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("rst_busy",       32'(busy),       32'd0);
        checkOutput("rst_mem_en",     32'(mem_en),     32'd0);
        checkOutput("rst_acks",       32'({cpu_ack, host_ack}), 32'd0);
        checkOutput("rst_cpu_rdata",  32'(cpu_rdata),  32'd0);
        checkOutput("rst_host_rdata", 32'(host_rdata), 32'd0);

        // First grant goes to the host; its write is issued in T1.
        reset = 1'b1;
        stepCycle();
        checkOutput("first_grant_host", 32'(grant_host), 32'd1);
        checkOutput("hw_mem_we",        32'(mem_we),     32'd1);
        checkOutput("hw_mem_addr",      32'(mem_addr),   32'h3F);
        checkOutput("hw_mem_wdata",     32'(mem_wdata),  32'h55);
        stepCycle();
        checkOutput("hw_ack_t2",  32'(host_ack), 32'd1);
        checkOutput("hw_busy_t2", 32'(busy),     32'd1);
        stepCycle();
        host_req = 1'b0;

        // CPU read of address 5 (memory holds 0xA7) now wins arbitration.
        stepCycle();
        c1 = cyc;
        checkOutput("cr_mem_en",   32'(mem_en),   32'd1);
        checkOutput("cr_mem_addr", 32'(mem_addr), 32'h05);
        waitAck(1'b0, "cr_ack_seen");
        checkOutput("cr_ack_latency", 32'(cyc - c1), 32'(RD_LAT + 1));
        checkOutput("cr_rdata",       32'(cpu_rdata),  32'hA7);
        checkOutput("cr_host_rdata",  32'(host_rdata), 32'd0);
        stepCycle();
        cpu_req = 1'b0;
        stepCycle();

        // Both held high: host gets HBM grants, then the CPU gets one.
        cpu_req = 1'b1;  cpu_we = 1'b1;  cpu_addr = 6'h20;  cpu_wdata = 8'h22;
        host_req = 1'b1; host_we = 1'b1; host_addr = 6'h10; host_wdata = 8'h11;
        acks = 0;
        order = '0;
        for (int n = 0; (n < 200) && (acks < 10); n++) begin
            stepCycle();
            if (host_ack) begin order = {order[8:0], 1'b1}; acks++; end
            if (cpu_ack)  begin order = {order[8:0], 1'b0}; acks++; end
        end
        checkOutput("burst_ack_count", 32'(acks),  32'd10);
        checkOutput("burst_order",     32'(order), 32'b11110_11110);
        stepCycle();
        cpu_req = 1'b0;
        host_req = 1'b0;
        stepCycle();

        // Reset asserted while a CPU read is waiting for memory.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h07;
        stepCycle();
        stepCycle();
        reset = 1'b0;
        stepCycle();
        checkOutput("wr_busy",   32'(busy),    32'd0);
        checkOutput("wr_ack",    32'(cpu_ack), 32'd0);
        checkOutput("wr_mem_en", 32'(mem_en),  32'd0);
        reset = 1'b1;
        exp7 = mem[7];
        waitAck(1'b0, "wr_retry_ack");
        checkOutput("wr_retry_rdata", 32'(cpu_rdata), 32'(exp7));
        stepCycle();
        cpu_req = 1'b0;
        stepCycle();

        // CPU drops its request in T1; the access must still finish once.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h09;
        stepCycle();
        cpu_req = 1'b0;
        cpu_addr = 6'h2A;
        waitAck(1'b0, "drop_ack_seen");
        stepCycle();
        checkOutput("drop_idle_busy", 32'(busy), 32'd0);
        stepCycle();
        checkOutput("drop_no_reack", 32'(cpu_ack), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            applyStimulus();
            stepCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
